// File: rtl/xadc_pkg.sv
// Shared constants and state types for the XADC DRP responder.
package xadc_pkg;

  // DRP register addresses
  localparam logic [6:0] XADC_TEMP_ADDR   = 7'h00;
  localparam logic [6:0] XADC_VAUX15_ADDR = 7'h1F;
  localparam logic [6:0] XADC_CFG0_ADDR   = 7'h40;
  localparam logic [6:0] XADC_CFG1_ADDR   = 7'h41;
  localparam logic [6:0] XADC_CFG2_ADDR   = 7'h42;

  // Conversion channels, alternated by the sequencer
  localparam logic [4:0] CH_TEMP   = 5'h00;
  localparam logic [4:0] CH_VAUX15 = 5'h1F;

  typedef enum logic {D_IDLE, D_WAIT} drp_state_t;
  typedef enum logic {S_CONV, S_EOC}  seq_state_t;

endpackage

// File: rtl/xadc_conv_sequencer.sv
// Free-running conversion sequencer: alternates channels 0x00/0x1F,
// CONV_CYCLES of conversion followed by a single end-of-conversion cycle.
module xadc_conv_sequencer
  import xadc_pkg::*;
#(
  parameter int CONV_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  output logic       upd,
  output logic [4:0] upd_ch,
  output logic       eoc_out,
  output logic       eos_out,
  output logic       busy_out,
  output logic [4:0] channel_out
);

  localparam int CW = $clog2(CONV_CYCLES);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(CONV_CYCLES - 1);

  seq_state_t state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic [4:0] ch, ch_nxt;
  logic [4:0] chan_nxt;
  logic       last;

  assign last = (cnt == LAST);

  // Sequencer state, counter, current channel and last-completed channel
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_CONV;
      cnt         <= '0;
      ch          <= CH_TEMP;
      channel_out <= CH_TEMP;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ch          <= ch_nxt;
      channel_out <= chan_nxt;
    end
  end

  // Next-state: count the conversion, publish the channel, then alternate
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    chan_nxt  = channel_out;
    case (state)
      S_CONV: begin
        if (last) begin
          state_nxt = S_EOC;
          chan_nxt  = ch;
        end else begin
          cnt_nxt = cnt + cnt_t'(1);
        end
      end
      S_EOC: begin
        state_nxt = S_CONV;
        cnt_nxt   = '0;
        ch_nxt    = (ch == CH_TEMP) ? CH_VAUX15 : CH_TEMP;
      end
    endcase
  end

  // Result-update strobe fires in the last conversion cycle
  assign upd      = (state == S_CONV) && last;
  assign upd_ch   = ch;
  assign eoc_out  = (state == S_EOC);
  assign eos_out  = eoc_out && (ch == CH_VAUX15);
  // Busy is forced low while reset is held so all outputs read 0 in reset
  assign busy_out = (state == S_CONV) && reset;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP responder: DRP slave with fixed access latency, shadow/result
// registers for temperature and VAUX15, and config storage at 0x40-0x42.
module xadc_drp_responder
  import xadc_pkg::*;
#(
  parameter int          DRP_LATENCY = 4,
  parameter int          CONV_CYCLES = 100,
  parameter logic [15:0] TEMP_INIT   = 16'h9A00,
  parameter logic [15:0] VOLT_INIT   = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        eoc_out,
  output logic        eos_out,
  output logic [4:0]  channel_out,
  output logic        busy_out,
  output logic        protocol_err
);

  localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY - 1);

  drp_state_t       state, state_nxt;
  logic [3:0]       lat_cnt, lat_cnt_nxt;
  logic [6:0]       addr_q, addr_nxt;
  logic             we_q, we_nxt;
  logic [15:0]      wdata_q, wdata_nxt;
  logic             drdy_nxt;
  logic             commit;
  logic [6:0]       rd_addr;
  logic             rd_we;
  logic [15:0]      rd_mux;

  logic [15:0]      temp_shadow, volt_shadow;
  logic [15:0]      temp_result, volt_result;
  logic [2:0][15:0] cfg;

  logic             upd;
  logic [4:0]       upd_ch;

  xadc_conv_sequencer #(
    .CONV_CYCLES(CONV_CYCLES)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .upd        (upd),
    .upd_ch     (upd_ch),
    .eoc_out    (eoc_out),
    .eos_out    (eos_out),
    .busy_out   (busy_out),
    .channel_out(channel_out)
  );

  // DRP FSM registers, latched request and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= D_IDLE;
      lat_cnt  <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      drdy_out <= 1'b0;
      do_out   <= '0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      addr_q   <= addr_nxt;
      we_q     <= we_nxt;
      wdata_q  <= wdata_nxt;
      drdy_out <= drdy_nxt;
      do_out   <= (drdy_nxt && !rd_we) ? rd_mux : 16'h0000;
    end
  end

  // DRP next-state: accept in idle, count down in wait, complete at zero.
  // drdy is registered, so it is scheduled one cycle ahead of completion.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    addr_nxt    = addr_q;
    we_nxt      = we_q;
    wdata_nxt   = wdata_q;
    drdy_nxt    = 1'b0;
    commit      = 1'b0;
    case (state)
      D_IDLE: begin
        if (den_in) begin
          state_nxt   = D_WAIT;
          lat_cnt_nxt = LAT_LOAD;
          addr_nxt    = daddr_in;
          we_nxt      = dwe_in;
          wdata_nxt   = di_in;
          drdy_nxt    = (LAT_LOAD == 4'd0);
        end
      end
      D_WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_nxt = D_IDLE;
          commit    = we_q;
        end else begin
          lat_cnt_nxt = lat_cnt - 4'd1;
          drdy_nxt    = (lat_cnt == 4'd1);
        end
      end
    endcase
  end

  // With single-cycle latency the capture happens while still idle
  assign rd_addr = (state == D_IDLE) ? daddr_in : addr_q;
  assign rd_we   = (state == D_IDLE) ? dwe_in   : we_q;

  // Read mux over the address map; unmapped addresses read zero
  always_comb begin
    rd_mux = 16'h0000;
    case (rd_addr)
      XADC_TEMP_ADDR:   rd_mux = temp_result;
      XADC_VAUX15_ADDR: rd_mux = volt_result;
      XADC_CFG0_ADDR:   rd_mux = cfg[0];
      XADC_CFG1_ADDR:   rd_mux = cfg[1];
      XADC_CFG2_ADDR:   rd_mux = cfg[2];
      default:          rd_mux = 16'h0000;
    endcase
  end

  // Register file: write commit on drdy, result copy on conversion end.
  // A same-cycle write and copy leaves the old shadow in the result.
  // NOTE: the config words are reset explicitly because software expects
  // them to read zero; a larger storage array would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      temp_shadow <= TEMP_INIT;
      volt_shadow <= VOLT_INIT;
      temp_result <= TEMP_INIT;
      volt_result <= VOLT_INIT;
      cfg         <= '0;
    end else begin
      if (commit) begin
        case (addr_q)
          XADC_TEMP_ADDR:   temp_shadow <= wdata_q;
          XADC_VAUX15_ADDR: volt_shadow <= wdata_q;
          XADC_CFG0_ADDR:   cfg[0]      <= wdata_q;
          XADC_CFG1_ADDR:   cfg[1]      <= wdata_q;
          XADC_CFG2_ADDR:   cfg[2]      <= wdata_q;
          default: ;
        endcase
      end
      if (upd) begin
        if (upd_ch == CH_TEMP) temp_result <= temp_shadow;
        else                   volt_result <= volt_shadow;
      end
    end
  end

  // Sticky flag for any strobe arriving while an access is outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      protocol_err <= 1'b0;
    end else if (den_in && (state == D_WAIT)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder: directed table, hand-written
// corner sequences and random DRP traffic against a cycle-count model.
module tb_xadc_drp_responder;

  localparam int          L         = 4;
  localparam int          CONV      = 100;
  localparam int          PERIOD    = CONV + 1;
  localparam logic [15:0] TEMP_INIT = 16'h9A00;
  localparam logic [15:0] VOLT_INIT = 16'h8000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        den_in = 1'b0;
  logic        dwe_in = 1'b0;
  logic [6:0]  daddr_in = 7'h00;
  logic [15:0] di_in = 16'h0000;
  logic [15:0] do_out;
  logic        drdy_out;
  logic        eoc_out;
  logic        eos_out;
  logic [4:0]  channel_out;
  logic        busy_out;
  logic        protocol_err;

  always #5 clk = ~clk;

  xadc_drp_responder #(
    .DRP_LATENCY(L),
    .CONV_CYCLES(CONV),
    .TEMP_INIT  (TEMP_INIT),
    .VOLT_INIT  (VOLT_INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .den_in      (den_in),
    .dwe_in      (dwe_in),
    .daddr_in    (daddr_in),
    .di_in       (di_in),
    .do_out      (do_out),
    .drdy_out    (drdy_out),
    .eoc_out     (eoc_out),
    .eos_out     (eos_out),
    .channel_out (channel_out),
    .busy_out    (busy_out),
    .protocol_err(protocol_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: register contents plus one outstanding access
  logic [15:0] m_shadow [2];
  logic [15:0] m_result [2];
  logic [15:0] m_cfg    [3];
  bit          m_err;
  bit          m_pend;
  bit          m_we;
  int          m_t;
  logic [6:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  // Last sampled outputs
  int          s_cyc;
  logic        s_drdy;
  logic [15:0] s_do;
  logic        s_eoc;
  logic        s_err;

  int          eoc_cyc_q [$];
  logic [4:0]  eoc_ch_q  [$];
  logic        eoc_eos_q [$];
  int          busy_low;

  typedef struct {
    bit          we;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [11];

  logic [6:0] addr_pool [7] = '{7'h00, 7'h1F, 7'h40, 7'h41, 7'h42, 7'h05, 7'h7F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow[0] = TEMP_INIT;
    m_shadow[1] = VOLT_INIT;
    m_result[0] = TEMP_INIT;
    m_result[1] = VOLT_INIT;
    for (int i = 0; i < 3; i++) m_cfg[i] = 16'h0000;
    m_err   = 1'b0;
    m_pend  = 1'b0;
    m_rdata = 16'h0000;
  endtask

  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      7'h00:               return m_result[0];
      7'h1F:               return m_result[1];
      7'h40, 7'h41, 7'h42: return m_cfg[int'(a) - 64];
      default:             return 16'h0000;
    endcase
  endfunction

  task automatic m_write(input logic [6:0] a, input logic [15:0] d);
    case (a)
      7'h00:               m_shadow[0] = d;
      7'h1F:               m_shadow[1] = d;
      7'h40, 7'h41, 7'h42: m_cfg[int'(a) - 64] = d;
      default: ;
    endcase
  endtask

  // Expected outputs for the current cycle, derived from the cycle number
  function automatic logic [25:0] m_outputs();
    bit          eoc;
    int          m;
    logic [4:0]  ch;
    bit          drdy;
    logic [15:0] dout;
    eoc  = (cyc >= CONV) && ((cyc - CONV) % PERIOD == 0);
    m    = (cyc >= CONV) ? (cyc - CONV) / PERIOD : -1;
    ch   = (m >= 0 && (m % 2) == 1) ? 5'h1F : 5'h00;
    drdy = m_pend && (cyc == m_t + L);
    dout = (drdy && !m_we) ? m_rdata : 16'h0000;
    return {drdy, dout, eoc, eoc && (ch == 5'h1F), ch, !eoc, m_err};
  endfunction

  // Advance the model across one clock edge using this cycle's inputs
  task automatic model_edge(input bit den, input bit we, input logic [6:0] a, input logic [15:0] d);
    logic [15:0] old_shadow [2];
    bit          upd;
    int          ch;
    old_shadow = m_shadow;
    upd = (cyc >= CONV - 1) && ((cyc - (CONV - 1)) % PERIOD == 0);
    ch  = (cyc >= CONV - 1) ? ((cyc - (CONV - 1)) / PERIOD) % 2 : 0;
    if (den) begin
      if (m_pend) m_err = 1'b1;
      else begin
        m_pend  = 1'b1;
        m_t     = cyc;
        m_we    = we;
        m_addr  = a;
        m_wdata = d;
      end
    end
    if (m_pend && (cyc == m_t + L - 1) && !m_we) m_rdata = m_read(m_addr);
    if (m_pend && (cyc == m_t + L)) begin
      if (m_we) m_write(m_addr, m_wdata);
      m_pend = 1'b0;
    end
    if (upd) m_result[ch] = old_shadow[ch];
  endtask

  // One clock cycle: drive, sample and check at negedge, advance model
  task automatic cycle(input bit den, input bit we, input logic [6:0] a, input logic [15:0] d);
    logic [25:0] obs;
    den_in   = den;
    dwe_in   = we;
    daddr_in = a;
    di_in    = d;
    @(negedge clk);
    obs    = {drdy_out, do_out, eoc_out, eos_out, channel_out, busy_out, protocol_err};
    s_cyc  = cyc;
    s_drdy = drdy_out;
    s_do   = do_out;
    s_eoc  = eoc_out;
    s_err  = protocol_err;
    if (reset) begin
      check($sformatf("outputs cycle %0d", cyc), 32'(obs), 32'(m_outputs()));
      if (eoc_out) begin
        eoc_cyc_q.push_back(cyc);
        eoc_ch_q.push_back(channel_out);
        eoc_eos_q.push_back(eos_out);
      end
      if (!busy_out) busy_low++;
      model_edge(den, we, a, d);
    end else begin
      check("outputs in reset", 32'(obs), 32'h0);
    end
    @(posedge clk);
    #1;
    cyc++;
    den_in   = 1'b0;
    dwe_in   = 1'b0;
    daddr_in = 7'h00;
    di_in    = 16'h0000;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 7'h00, 16'h0000);
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) idle();
  endtask

  // Reset for n cycles, released at the start of cycle 0
  task automatic hold_reset(input int n);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) idle();
    reset = 1'b1;
    cyc   = 0;
    eoc_cyc_q.delete();
    eoc_ch_q.delete();
    eoc_eos_q.delete();
    busy_low = 0;
  endtask

  task automatic drp_access(input bit we, input logic [6:0] a, input logic [15:0] d,
                            output logic [15:0] rd, output int lat);
    int start;
    bit got;
    start = cyc;
    got   = 1'b0;
    rd    = 16'hxxxx;
    lat   = -1;
    cycle(1'b1, we, a, d);
    for (int i = 0; i < 2 * L + 4 && !got; i++) begin
      idle();
      if (s_drdy) begin
        got = 1'b1;
        rd  = s_do;
        lat = s_cyc - start;
      end
    end
    check($sformatf("drdy seen addr %h", a), 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int          lat;
    int          t0;
    int          drdy_cnt;
    int          first_drdy;
    int          err_from;
    int          first_eoc;

    vecs[0]  = '{1'b0, 7'h1F, 16'h0000, 16'h8000};
    vecs[1]  = '{1'b0, 7'h05, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 7'h41, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 7'h41, 16'h0000, 16'hBEEF};
    vecs[4]  = '{1'b1, 7'h05, 16'h1111, 16'h0000};
    vecs[5]  = '{1'b0, 7'h05, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 7'h00, 16'h0000, 16'h9A00};
    vecs[7]  = '{1'b0, 7'h40, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 7'h42, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 7'h1F, 16'h1234, 16'h0000};
    vecs[10] = '{1'b0, 7'h1F, 16'h0000, 16'h8000};

    @(posedge clk);
    #1;
    hold_reset(3);

    // First read at cycle 10 completes at cycle 14
    idle_until(10);
    drp_access(1'b0, 7'h00, 16'h0000, rd, lat);
    check("temp read data", 32'(rd), 32'(TEMP_INIT));
    check("temp read latency", 32'(lat), 32'(L));
    idle();
    check("do cleared after drdy", 32'(s_do), 32'h0);
    check("protocol_err clean", 32'(s_err), 32'h0);

    // Directed access table, all before the first result update
    for (int i = 0; i < 11; i++) begin
      drp_access(vecs[i].we, vecs[i].addr, vecs[i].data, rd, lat);
      check($sformatf("vec %0d data", i), 32'(rd), 32'(vecs[i].exp));
      check($sformatf("vec %0d latency", i), 32'(lat), 32'(L));
    end

    // VAUX15 shadow becomes visible after the 0x1F conversion at 201
    idle_until(202);
    drp_access(1'b0, 7'h1F, 16'h0000, rd, lat);
    check("vaux15 after eoc", 32'(rd), 32'h1234);

    // Second strobe two cycles into an access
    t0         = cyc;
    drdy_cnt   = 0;
    first_drdy = -1;
    err_from   = -1;
    for (int i = 0; i < 12; i++) begin
      cycle((i == 0) || (i == 2), 1'b0, (i == 0) ? 7'h00 : 7'h1F, 16'h0000);
      if (s_drdy) begin
        drdy_cnt++;
        first_drdy = s_cyc;
      end
      if (s_err && err_from < 0) err_from = s_cyc;
    end
    check("overlap drdy count", 32'(drdy_cnt), 32'd1);
    check("overlap drdy cycle", 32'(first_drdy - t0), 32'(L));
    check("protocol_err onset", 32'(err_from - t0), 32'd3);

    // Free-run conversion timeline over the first 405 cycles
    idle_until(405);
    check("eoc count", 32'(eoc_cyc_q.size()), 32'd4);
    for (int i = 0; i < eoc_cyc_q.size() && i < 4; i++) begin
      check($sformatf("eoc %0d cycle", i), 32'(eoc_cyc_q[i]), 32'(CONV + PERIOD * i));
      check($sformatf("eoc %0d channel", i), 32'(eoc_ch_q[i]), (i % 2 == 1) ? 32'h1F : 32'h00);
      check($sformatf("eoc %0d eos", i), 32'(eoc_eos_q[i]), 32'(i % 2));
    end
    check("busy low cycles", 32'(busy_low), 32'd4);

    // Random DRP traffic, including strobes during outstanding accesses
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            addr_pool[$urandom_range(0, 6)], 16'($urandom));
    end
    check("protocol_err sticky", 32'(s_err), 32'h1);

    // Dirty the registers, then reset in the middle of an access
    for (int i = 0; i < 2 * L; i++) idle();
    drp_access(1'b1, 7'h1F, 16'h5555, rd, lat);
    drp_access(1'b1, 7'h00, 16'h6666, rd, lat);
    drp_access(1'b1, 7'h41, 16'h7777, rd, lat);
    cycle(1'b1, 1'b0, 7'h00, 16'h0000);
    idle();
    hold_reset(3);
    drdy_cnt  = 0;
    first_eoc = -1;
    for (int i = 0; i < CONV + 20 && first_eoc < 0; i++) begin
      idle();
      if (s_drdy) drdy_cnt++;
      if (s_eoc) first_eoc = s_cyc;
    end
    check("no drdy after reset", 32'(drdy_cnt), 32'd0);
    check("first eoc after reset", 32'(first_eoc), 32'(CONV));
    check("protocol_err cleared", 32'(s_err), 32'h0);
    drp_access(1'b0, 7'h00, 16'h0000, rd, lat);
    check("temp after reset", 32'(rd), 32'(TEMP_INIT));
    drp_access(1'b0, 7'h41, 16'h0000, rd, lat);
    check("cfg after reset", 32'(rd), 32'h0);
    idle_until(2 * PERIOD + 1);
    drp_access(1'b0, 7'h1F, 16'h0000, rd, lat);
    check("vaux15 shadow after reset", 32'(rd), 32'(VOLT_INIT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xadc_drp_responder.md
Name: xadc_drp_responder

Overview:
- Synthesizable responder for the XADC DRP port. It has the same port-level behaviour as xadc_wiz_0: a DRP slave, a conversion sequencer, and eoc/eos/busy/channel_out.
- It replaces the XADC primitive in simulation and board-less bring-up, so that xadc_dual_channel and the downstream temperature and voltage monitors run against known, injectable codes.
- Sample values are injected by DRP writes to shadow registers. They become readable only after the next conversion of that channel.

Parameters:
- DRP_LATENCY, 4: cycles from an accepted den_in to drdy_out (legal range 1..15).
- CONV_CYCLES, 100: cycles per conversion, counted from conversion start to the eoc pulse (legal minimum 2).
- TEMP_INIT, 16'h9A00: reset value of the temperature shadow and result registers.
- VOLT_INIT, 16'h8000: reset value of the VAUX15 shadow and result registers.

Ports:
- clk  in  1  DRP and sequencer clock.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- den_in  in  1  DRP enable, one-cycle strobe.
- dwe_in  in  1  DRP write enable, qualified by den_in.
- daddr_in  in  7  DRP address.
- di_in  in  16  DRP write data.
- do_out  out  16  DRP read data, valid only while drdy_out=1.
- drdy_out  out  1  one-cycle DRP completion pulse.
- eoc_out  out  1  one-cycle end-of-conversion pulse.
- eos_out  out  1  one-cycle end-of-sequence pulse, coincident with eoc_out for channel 5'h1F.
- channel_out  out  5  channel of the last completed conversion.
- busy_out  out  1  high while a conversion is in progress.
- protocol_err  out  1  sticky; set on any den_in received while a DRP access is outstanding.

Behaviour:
- Reset values (while reset=0): all outputs 0, except channel_out=5'h00. Shadow and result registers are set to TEMP_INIT/VOLT_INIT. Config registers 0x40–0x42 are 0. DRP FSM = D_IDLE, sequencer = S_CONV on channel 0x00, conversion counter = 0. Reset deasserting mid-access drops that access; no drdy is produced for it.
- Address map:
  - 0x00: read = temperature result; write = temperature shadow.
  - 0x1F: read = VAUX15 result; write = VAUX15 shadow.
  - 0x40–0x42: read/write config storage, with no functional effect.
  - Any other address: reads 16'h0000, writes are discarded.
- DRP FSM, states D_IDLE and D_WAIT:
  - D_IDLE with den_in=1: latch daddr_in, dwe_in and di_in; load the latency counter with DRP_LATENCY-1; go to D_WAIT.
  - D_WAIT: decrement the counter. At 0, assert drdy_out for exactly one cycle and return to D_IDLE.
  - Access timing: den_in at cycle T gives drdy_out at T+DRP_LATENCY.
- Read data: do_out is registered and takes the value of the addressed register as of cycle T+DRP_LATENCY-1. A result update in that same cycle is not visible; an update one cycle earlier is. do_out returns to 0 when drdy_out=0.
- Write commit: the shadow or config register is updated in the cycle drdy_out is asserted. do_out=0 on writes.
- den_in while in D_WAIT: ignored, sets protocol_err, and does not disturb the outstanding access. protocol_err clears only on reset.
- A new den_in in the same cycle as drdy_out is also an error. The next access may start in the cycle after drdy_out.
- Sequencer states S_CONV and S_EOC; channel order 0x00, 0x1F, 0x00, ...
  - S_CONV: busy_out=1; counter runs 0..CONV_CYCLES-1.
  - Counter at CONV_CYCLES-1: copy the shadow of the current channel to its result register, set channel_out to the current channel, go to S_EOC.
  - S_EOC (1 cycle): eoc_out=1; eos_out=1 when the channel is 0x1F; busy_out=0. Then switch channel, clear the counter, return to S_CONV.
  - eoc period = CONV_CYCLES+1 cycles.
- Free-running: the sequencer starts immediately after reset and is independent of DRP activity.
- DRP write to a shadow in the same cycle its result is updated: the result receives the old shadow, and the new value appears at that channel's next conversion.

Decomposition:
- Package xadc_pkg:
  - Address constants XADC_TEMP_ADDR=7'h00, XADC_VAUX15_ADDR=7'h1F, XADC_CFG0_ADDR=7'h40.
  - Channel constants.
  - drp_state_t (D_IDLE, D_WAIT) and seq_state_t (S_CONV, S_EOC).
- One natural sub-module, xadc_conv_sequencer: counter, channel alternation, eoc/eos/busy/channel_out generation, and result-update strobe. The DRP FSM and register file remain in the top.

Test Plan:
- Reset, then a read of 0x00 at T=10 (default parameters) -> drdy_out at T=14 with do_out=16'h9A00 for one cycle; do_out=0 at T=15; protocol_err=0.
- Write 16'h1234 to 0x1F, then read 0x1F before the next 0x1F eoc -> 16'h8000. Read 0x1F after that eoc -> 16'h1234, and eos_out=1 coincident with that eoc_out.
- Free run for 404 cycles after reset -> eoc_out at cycles 100, 201, 302, 403. channel_out follows 00, 1F, 00, 1F. eos_out only at 201 and 403. busy_out=0 only in eoc cycles.
- den_in at T and again at T+2 -> exactly one drdy_out, at T+4; protocol_err=1 from T+3 and held until reset.
- Read of 0x05 -> 16'h0000. Write 16'hBEEF to 0x41 then read it back -> 16'hBEEF. Write to 0x05 -> no register changes.
- Assert reset during D_WAIT at cycle T+2 and release 3 cycles later -> no drdy_out, registers back to TEMP_INIT/VOLT_INIT, and the first eoc CONV_CYCLES cycles after release.
